// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with active-low strobes, registered occupancy flags
// and one-cycle overflow/underflow pulses for rejected requests.
module sync_fifo_param #(
    parameter int W      = 8,
    parameter int L      = 5,
    parameter int AF_LVL = (1 << L) - 2,
    parameter int AE_LVL = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_n,
    input  logic [W-1:0] din,
    input  logic         rd_n,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [L:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam int         DEPTH    = 1 << L;
    localparam logic [L:0] FULL_CNT = (L + 1)'(DEPTH);
    localparam logic [L:0] AF_CNT   = (L + 1)'(AF_LVL);
    localparam logic [L:0] AE_CNT   = (L + 1)'(AE_LVL);

    logic [W-1:0] mem [DEPTH];
    logic [L-1:0] wr_ptr;
    logic [L-1:0] rd_ptr;
    logic         wr_acc;
    logic         rd_acc;
    logic [L:0]   count_next;

    // A write into a full FIFO is still legal when a read frees a slot on the same edge.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rd_acc     = !rd_n && !empty;
        wr_acc     = !wr_n && (!full || rd_acc);
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + (L + 1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - (L + 1)'(1);
        end
    end

    // NOTE: the storage array has no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            dout         <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + L'(1);
            end
            if (rd_acc) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + L'(1);
            end
            // Flags come from the next count so they stay in step with count every cycle.
            count        <= count_next;
            full         <= (count_next == FULL_CNT);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_CNT);
            almost_empty <= (count_next <= AE_CNT);
            overflow     <= !wr_n && !wr_acc;
            underflow    <= !rd_n && !rd_acc;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (depth 4, AF_LVL=3, AE_LVL=1): stimulus queues
// hand-computed per-cycle expectations, a monitor compares them after each rising edge.
module tb_sync_fifo_param;

    localparam int W = 8;
    localparam int L = 2;

    logic         clk;
    logic         rst_n;
    logic         wr_n;
    logic [W-1:0] din;
    logic         rd_n;
    logic [W-1:0] dout;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [L:0]   count;
    logic         overflow;
    logic         underflow;

    typedef struct {
        int          cnt;
        logic [7:0]  dv;
        logic [3:0]  fl;   // {full, empty, almost_full, almost_empty}
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sync_fifo_param #(.W(W), .L(L), .AF_LVL(3), .AE_LVL(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_n         (wr_n),
        .din          (din),
        .rd_n         (rd_n),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // One stimulus cycle: drive on the falling edge, queue what the next rising edge must produce.
    task automatic vec(input bit w, input logic [7:0] d, input bit r, input int cnt,
                       input logic [7:0] dv, input logic [3:0] fl, input bit o, input bit u);
        exp_t e;
        @(negedge clk);
        wr_n = !w;
        din  = d;
        rd_n = !r;
        e.cnt = cnt; e.dv = dv; e.fl = fl; e.ovf = o; e.unf = u;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("count",     32'(count), 32'(e.cnt));
            check("dout",      32'(dout), 32'(e.dv));
            check("flags",     32'({full, empty, almost_full, almost_empty}), 32'(e.fl));
            check("overflow",  32'(overflow), 32'(e.ovf));
            check("underflow", 32'(underflow), 32'(e.unf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wr_n  = 1'b1;
        rd_n  = 1'b1;
        din   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        repeat (3) vec(0, 8'h00, 0, 0, 8'h00, 4'b0101, 0, 0);

        // Fill, then overflow
        vec(1, 8'hA1, 0, 1, 8'h00, 4'b0001, 0, 0);
        vec(1, 8'hB2, 0, 2, 8'h00, 4'b0000, 0, 0);
        vec(1, 8'hC3, 0, 3, 8'h00, 4'b0010, 0, 0);
        vec(1, 8'hD4, 0, 4, 8'h00, 4'b1010, 0, 0);
        vec(1, 8'hEE, 0, 4, 8'h00, 4'b1010, 1, 0);
        vec(0, 8'h00, 0, 4, 8'h00, 4'b1010, 0, 0);

        // Drain, then underflow
        vec(0, 8'h00, 1, 3, 8'hA1, 4'b0010, 0, 0);
        vec(0, 8'h00, 1, 2, 8'hB2, 4'b0000, 0, 0);
        vec(0, 8'h00, 1, 1, 8'hC3, 4'b0001, 0, 0);
        vec(0, 8'h00, 1, 0, 8'hD4, 4'b0101, 0, 0);
        vec(0, 8'h00, 1, 0, 8'hD4, 4'b0101, 0, 1);
        vec(0, 8'h00, 0, 0, 8'hD4, 4'b0101, 0, 0);

        // Pointer wrap
        vec(1, 8'h01, 0, 1, 8'hD4, 4'b0001, 0, 0);
        vec(1, 8'h02, 0, 2, 8'hD4, 4'b0000, 0, 0);
        vec(1, 8'h03, 0, 3, 8'hD4, 4'b0010, 0, 0);
        vec(0, 8'h00, 1, 2, 8'h01, 4'b0000, 0, 0);
        vec(0, 8'h00, 1, 1, 8'h02, 4'b0001, 0, 0);
        vec(0, 8'h00, 1, 0, 8'h03, 4'b0101, 0, 0);
        vec(1, 8'h11, 0, 1, 8'h03, 4'b0001, 0, 0);
        vec(1, 8'h12, 0, 2, 8'h03, 4'b0000, 0, 0);
        vec(1, 8'h13, 0, 3, 8'h03, 4'b0010, 0, 0);
        vec(1, 8'h14, 0, 4, 8'h03, 4'b1010, 0, 0);
        vec(0, 8'h00, 1, 3, 8'h11, 4'b0010, 0, 0);
        vec(0, 8'h00, 1, 2, 8'h12, 4'b0000, 0, 0);
        vec(0, 8'h00, 1, 1, 8'h13, 4'b0001, 0, 0);
        vec(0, 8'h00, 1, 0, 8'h14, 4'b0101, 0, 0);

        // Simultaneous read/write at full
        vec(1, 8'h21, 0, 1, 8'h14, 4'b0001, 0, 0);
        vec(1, 8'h22, 0, 2, 8'h14, 4'b0000, 0, 0);
        vec(1, 8'h23, 0, 3, 8'h14, 4'b0010, 0, 0);
        vec(1, 8'h24, 0, 4, 8'h14, 4'b1010, 0, 0);
        vec(1, 8'h55, 1, 4, 8'h21, 4'b1010, 0, 0);
        vec(0, 8'h00, 1, 3, 8'h22, 4'b0010, 0, 0);
        vec(0, 8'h00, 1, 2, 8'h23, 4'b0000, 0, 0);
        vec(0, 8'h00, 1, 1, 8'h24, 4'b0001, 0, 0);
        vec(0, 8'h00, 1, 0, 8'h55, 4'b0101, 0, 0);

        // Simultaneous read/write at empty: write wins, read rejected, no bypass
        vec(1, 8'h66, 1, 1, 8'h55, 4'b0001, 0, 1);
        vec(0, 8'h00, 1, 0, 8'h66, 4'b0101, 0, 0);

        // Asynchronous reset mid-burst
        vec(1, 8'h77, 0, 1, 8'h66, 4'b0001, 0, 0);
        vec(1, 8'h88, 0, 2, 8'h66, 4'b0000, 0, 0);
        @(negedge clk);
        check("queue_drained_before_reset", 32'(exp_q.size()), 32'd0);
        wr_n = 1'b1;
        rd_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_dout",  32'(dout), 32'h00);
        check("rst_flags", 32'({full, empty, almost_full, almost_empty}), 32'b0101);
        check("rst_pulses", 32'({overflow, underflow}), 32'b00);
        #1 rst_n = 1'b1;

        // Normal operation after reset; old data discarded
        vec(0, 8'h00, 0, 0, 8'h00, 4'b0101, 0, 0);
        vec(1, 8'h99, 0, 1, 8'h00, 4'b0001, 0, 0);
        vec(0, 8'h00, 1, 0, 8'h99, 4'b0101, 0, 0);
        vec(0, 8'h00, 1, 0, 8'h99, 4'b0101, 0, 1);

        @(negedge clk);
        wr_n = 1'b1;
        rd_n = 1'b1;
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
